// File: rtl/ts_pkg.sv
// Shared task-scheduler definitions: default geometry and loader FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ts_pkg;

  localparam int DEF_NUM_OF_CORES   = 4;
  localparam int DEF_INSN_LOAD_TIME = 16;
  localparam int DEF_INSN_WIDTH     = 16;
  localparam int DEF_REG_WIDTH      = 8;

  // Loader FSM: IDLE waits for this core's Start, RUN waits for core_done.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ld_state_t;

endpackage

// File: rtl/frame_bank_2x.sv
// Two-bank instruction frame store: one bank is written while the other is read.
// Latency: write lands on the clock edge; read is combinational.
// Backpressure: none, the write port accepts a word every cycle.
module frame_bank_2x #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_bank_sel,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_dat,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_dat
);

  // Bank index is the address MSB; contents are deliberately not reset.
  logic [WIDTH-1:0] r_mem [0:2*DEPTH-1];

  // Capture always targets the staging bank (the one not selected for reads).
  always_ff @(posedge clk) begin
    r_mem[{~i_bank_sel, i_wr_addr}] <= i_wr_dat;
  end

  assign o_rd_dat = r_mem[{i_bank_sel, i_rd_addr}];

endmodule

// File: rtl/core_task_loader.sv
// Per-core loader: captures the broadcast frame, latches R0, hands off to the core on Start.
// Latency: Start at t -> core_start and new frame on fetch port at t+1; core_done at t -> Ready at t+1.
// Backpressure: Ready low while the core runs; a Start during RUN is dropped and flagged in proto_err.
module core_task_loader
  import ts_pkg::*;
#(
  parameter int CORE_ID        = 0,
  parameter int NUM_OF_CORES   = DEF_NUM_OF_CORES,
  parameter int INSN_LOAD_TIME = DEF_INSN_LOAD_TIME,
  parameter int INSN_WIDTH     = DEF_INSN_WIDTH,
  parameter int REG_WIDTH      = DEF_REG_WIDTH,
  localparam int CW            = $clog2(INSN_LOAD_TIME)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [CW-1:0]                     Insn_Load_Counter,
  input  logic [INSN_WIDTH-1:0]             Insn_Data,
  input  logic [NUM_OF_CORES-1:0]           Start,
  input  logic [NUM_OF_CORES-1:0]           Init_R0_Vect,
  input  logic [NUM_OF_CORES*REG_WIDTH-1:0] Init_R0,
  output logic                              Ready,
  output logic                              core_start,
  input  logic                              core_done,
  input  logic [CW-1:0]                     fetch_pc,
  output logic [INSN_WIDTH-1:0]             fetch_insn,
  output logic [REG_WIDTH-1:0]              r0_value,
  output logic                              r0_valid,
  output logic                              proto_err
);

  ld_state_t           r_state;
  ld_state_t           w_state_nxt;
  logic [CW-1:0]       r_cnt_d;
  logic                r_bank_sel;
  logic                w_start_own;
  logic                w_r0_ld;
  logic [REG_WIDTH-1:0] w_r0_slice;
  logic                w_accept;
  logic                w_perr_set;
  logic                w_unused;

  assign w_start_own = Start[CORE_ID];
  assign w_r0_ld     = Init_R0_Vect[CORE_ID];
  assign w_r0_slice  = Init_R0[CORE_ID*REG_WIDTH +: REG_WIDTH];

  // Other cores' strobes and R0 slices are intentionally ignored.
  assign w_unused = ^{Start, Init_R0_Vect, Init_R0};

  // Insn_Data lags the counter by one cycle, so delay the counter to align the write address.
  always_ff @(posedge clk) begin
    if (reset) r_cnt_d <= CW'(INSN_LOAD_TIME - 1);
    else       r_cnt_d <= Insn_Load_Counter;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: accept Start only when idle; a Start while running is an error, done still wins.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_perr_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_own) begin
          w_state_nxt = ST_RUN;
          w_accept    = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_start_own) w_perr_set  = 1'b1;
        if (core_done)   w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bank swap, start pulse and sticky error; banks themselves survive reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bank_sel <= 1'b0;
      core_start <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      core_start <= w_accept;
      if (w_accept)   r_bank_sel <= ~r_bank_sel;
      if (w_perr_set) proto_err  <= 1'b1;
    end
  end

  // R0 latch: a load in the core_start cycle takes priority over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r0_value <= '0;
      r0_valid <= 1'b0;
    end else if (w_r0_ld) begin
      r0_value <= w_r0_slice;
      r0_valid <= 1'b1;
    end else if (core_start) begin
      r0_valid <= 1'b0;
    end
  end

  // Drop Ready in the accepting cycle so the scheduler never sees a stale idle core.
  assign Ready = (r_state == ST_IDLE) & ~w_start_own;

  frame_bank_2x #(
    .DEPTH (INSN_LOAD_TIME),
    .WIDTH (INSN_WIDTH),
    .AW    (CW)
  ) u_bank (
    .clk        (clk),
    .i_bank_sel (r_bank_sel),
    .i_wr_addr  (r_cnt_d),
    .i_wr_dat   (Insn_Data),
    .i_rd_addr  (fetch_pc),
    .o_rd_dat   (fetch_insn)
  );

endmodule

// File: tb/tb_core_task_loader.sv
// Scoreboard bench for core_task_loader: stimulus queues expectations, a monitor pops and compares.
// Latency: checks are tagged with the cycle in which the output must hold.
// Backpressure: n/a.
module tb_core_task_loader;

  localparam int CID = 1;
  localparam int NC  = 4;
  localparam int RW  = 8;

  localparam int K_READY = 0;
  localparam int K_PERR  = 1;
  localparam int K_R0V   = 2;
  localparam int K_R0VAL = 3;
  localparam int K_INSN  = 4;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] val;
    string       name;
  } chk_t;

  logic           clk;
  logic           reset;
  logic [3:0]     Insn_Load_Counter;
  logic [15:0]    Insn_Data;
  logic [NC-1:0]  Start;
  logic [NC-1:0]  Init_R0_Vect;
  logic [NC*RW-1:0] Init_R0;
  logic           Ready;
  logic           core_start;
  logic           core_done;
  logic [3:0]     fetch_pc;
  logic [15:0]    fetch_insn;
  logic [RW-1:0]  r0_value;
  logic           r0_valid;
  logic           proto_err;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  chk_t chk_q[$];
  int   start_q[$];

  core_task_loader #(
    .CORE_ID        (CID),
    .NUM_OF_CORES   (NC),
    .INSN_LOAD_TIME (16),
    .INSN_WIDTH     (16),
    .REG_WIDTH      (RW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .Insn_Load_Counter (Insn_Load_Counter),
    .Insn_Data         (Insn_Data),
    .Start             (Start),
    .Init_R0_Vect      (Init_R0_Vect),
    .Init_R0           (Init_R0),
    .Ready             (Ready),
    .core_start        (core_start),
    .core_done         (core_done),
    .fetch_pc          (fetch_pc),
    .fetch_insn        (fetch_insn),
    .r0_value          (r0_value),
    .r0_valid          (r0_valid),
    .proto_err         (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int kind, input int off, input logic [15:0] v);
    chk_t c;
    c.cyc  = cyc + off;
    c.kind = kind;
    c.val  = v;
    c.name = nm;
    chk_q.push_back(c);
  endtask

  task automatic exp_start(input int off);
    start_q.push_back(cyc + off);
  endtask

  task automatic set_r0(input logic [7:0] own);
    Init_R0 = 32'h1111_1111;
    Init_R0[CID*RW +: RW] = own;
  endtask

  // Counter i in cycle i, word i-1 on the data bus (data lags the counter by one).
  task automatic stream(input logic [15:0] base);
    for (int i = 0; i < 16; i++) begin
      Insn_Load_Counter = 4'(i);
      if (i > 0) Insn_Data = base + 16'(i - 1);
      tick();
    end
  endtask

  // Monitor: core_start pulses are matched against expected cycles, value checks by cycle tag.
  always @(negedge clk) begin
    logic [15:0] act;
    chk_t        c;
    int          e;
    if (core_start === 1'b1) begin
      n_chk++;
      if (start_q.size() == 0) begin
        n_fail++;
        $display("FAIL core_start: unexpected pulse at cycle %0d (got 1, want 0)", cyc);
      end else begin
        e = start_q.pop_front();
        if (e != cyc) begin
          n_fail++;
          $display("FAIL core_start: pulse at cycle %0d, want cycle %0d", cyc, e);
        end
      end
    end
    while (start_q.size() > 0 && start_q[0] < cyc) begin
      e = start_q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL core_start: no pulse at cycle %0d (got 0, want 1)", e);
    end
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
      c = chk_q.pop_front();
      case (c.kind)
        K_READY: act = {15'b0, Ready};
        K_PERR:  act = {15'b0, proto_err};
        K_R0V:   act = {15'b0, r0_valid};
        K_R0VAL: act = {8'b0, r0_value};
        default: act = fetch_insn;
      endcase
      n_chk++;
      if (act !== c.val) begin
        n_fail++;
        $display("FAIL %s: cycle %0d got 0x%0h want 0x%0h", c.name, cyc, act, c.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    Insn_Load_Counter = '0;
    Insn_Data = '0;
    Start = '0;
    Init_R0_Vect = '0;
    Init_R0 = '0;
    core_done = 1'b0;
    fetch_pc = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", K_READY, 0, 16'h1);
    chk("rst_perr",  K_PERR,  0, 16'h0);
    chk("rst_r0v",   K_R0V,   0, 16'h0);
    chk("rst_r0val", K_R0VAL, 0, 16'h0);
    tick();

    // Foreign R0 strobe must not load.
    Init_R0_Vect = 4'b0001;
    set_r0(8'h77);
    tick();
    Init_R0_Vect = '0;
    chk("foreign_r0v", K_R0V, 0, 16'h0);
    Init_R0_Vect = NC'(1 << CID);
    set_r0(8'hA5);
    tick();
    Init_R0_Vect = '0;
    chk("r0_load_v",   K_R0V,   0, 16'h1);
    chk("r0_load_val", K_R0VAL, 0, 16'h00A5);

    // Frame 1, foreign start in the hold cycle (last word on the bus).
    stream(16'h1000);
    Insn_Data = 16'h100F;
    Start = NC'(1 << (CID + 1));
    chk("foreign_start_ready", K_READY, 0, 16'h1);
    tick();
    Start = '0;
    chk("foreign_start_ready_next", K_READY, 0, 16'h1);
    tick();

    // Accepted start.
    Start = NC'(1 << CID);
    chk("start_ready_drop", K_READY, 0, 16'h0);
    exp_start(1);
    tick();
    Start = '0;
    fetch_pc = 4'd5;
    chk("f1_pc5",        K_INSN,  0, 16'h1005);
    chk("run_ready",     K_READY, 0, 16'h0);
    chk("r0v_at_start",  K_R0V,   0, 16'h1);
    tick();
    fetch_pc = 4'd15;
    chk("f1_pc15",        K_INSN,  0, 16'h100F);
    chk("r0v_cleared",    K_R0V,   0, 16'h0);
    chk("r0val_kept",     K_R0VAL, 0, 16'h00A5);
    tick();

    // Frame 2 streamed while the core runs frame 1.
    fetch_pc = 4'd3;
    stream(16'h2000);
    Insn_Data = 16'h200F;
    core_done = 1'b1;
    chk("dbuf_pc3_old", K_INSN,  0, 16'h1003);
    chk("done_ready",   K_READY, 0, 16'h0);
    tick();
    core_done = 1'b0;
    chk("idle_after_done", K_READY, 0, 16'h1);
    Init_R0_Vect = NC'(1 << CID);
    set_r0(8'hA5);
    tick();
    Init_R0_Vect = '0;
    chk("r0v_idle_load", K_R0V, 0, 16'h1);
    Start = NC'(1 << CID);
    chk("start2_ready", K_READY, 0, 16'h0);
    exp_start(1);
    tick();
    Start = '0;
    fetch_pc = 4'd3;
    chk("f2_pc3", K_INSN, 0, 16'h2003);
    Init_R0_Vect = NC'(1 << CID);
    set_r0(8'h3C);
    chk("r0v_before_reload", K_R0V, 0, 16'h1);
    tick();
    Init_R0_Vect = '0;
    chk("reload_r0v",   K_R0V,   0, 16'h1);
    chk("reload_r0val", K_R0VAL, 0, 16'h003C);
    chk("perr_clean",   K_PERR,  0, 16'h0);
    fetch_pc = 4'd0;
    chk("f2_pc0", K_INSN, 0, 16'h2000);
    tick();

    // Start while running: flagged and ignored.
    Start = NC'(1 << CID);
    chk("illegal_ready", K_READY, 0, 16'h0);
    tick();
    Start = '0;
    chk("illegal_perr",  K_PERR,  0, 16'h1);
    chk("still_run",     K_READY, 0, 16'h0);
    tick();

    // Reset mid-RUN: back to idle, banks retained.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fetch_pc = 4'd3;
    chk("rst2_ready", K_READY, 0, 16'h1);
    chk("rst2_perr",  K_PERR,  0, 16'h0);
    chk("rst2_r0v",   K_R0V,   0, 16'h0);
    chk("rst2_r0val", K_R0VAL, 0, 16'h0);
    chk("rst2_bank_kept", K_INSN, 0, 16'h2003);
    tick();
    Start = NC'(1 << CID);
    exp_start(1);
    tick();
    Start = '0;
    fetch_pc = 4'd5;
    chk("f1_again_pc5", K_INSN, 0, 16'h1005);
    tick();

    // Start and done together in RUN.
    Start = NC'(1 << CID);
    core_done = 1'b1;
    chk("simul_ready", K_READY, 0, 16'h0);
    tick();
    Start = '0;
    core_done = 1'b0;
    chk("simul_idle", K_READY, 0, 16'h1);
    chk("simul_perr", K_PERR,  0, 16'h1);
    tick();
    tick();
    tick();

    while (chk_q.size() > 0) begin
      chk_t c;
      c = chk_q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s: check for cycle %0d never evaluated", c.name, c.cyc);
    end
    while (start_q.size() > 0) begin
      int e;
      e = start_q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL core_start: no pulse at cycle %0d (got 0, want 1)", e);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
